tx_initiated_sweep_test_tx: RTL and testbench
=============================================

Name: tx_initiated_sweep_test_tx

Overview:
TX-side controller for a multi-point TX-initiated sideband test. It sweeps the PI phase over a programmable step range and runs one full point-test handshake per step: START, LFSR_CLEAR, pattern burst, RESULT, END. It collects per-lane pass results, tracks the longest contiguous passing window, and reports eye width and centre to the LTSM. It sits between the LTSM, the sideband encoder/decoder and the mainband/valtrain pattern generators, with a response timeout on every sideband wait.

Parameters:
NUM_LANES, 16, lanes covered by the per-lane result field of the RESULT response
PI_STEP_W, 4, PI step control-word width
TIMEOUT_CYCLES, 8000, max cycles waiting for a sideband response (must be >= 2)
TO_W, 13, timeout counter width, ceil(log2(TIMEOUT_CYCLES+1))

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_en  in  1  level; rising 0->1 starts a sweep; 0 aborts and returns to IDLE
i_mainband_or_valtrain_test  in  1  0 mainband, 1 valtrain; sampled at start
i_lfsr_or_perlane  in  1  0 LFSR, 1 per-lane ID; sampled at start
i_step_min, i_step_max  in  PI_STEP_W each  inclusive sweep bounds; sampled at start
i_lane_mask  in  NUM_LANES  lanes that must pass; sampled at start
i_pattern_finished  in  1  pattern generator burst done (pulse)
i_decoded_sideband_message  in  4  decoded incoming message, valid when i_rx_valid
i_rx_valid  in  1  incoming sideband message valid
i_data_bits  in  16  sideband data; [NUM_LANES-1:0] = lane pass bits on RESULT response
i_busy_negedge_detected  in  1  sideband transmitter finished the current message
o_encoded_sideband_message  out  4  outgoing message code
o_valid  out  1  outgoing message valid
o_sb_data_pattern, o_sb_burst_count, o_sb_comparison_mode  out  1 each  START request fields
o_val_pattern_en  out  1  valtrain pattern generator enable
o_mainband_pattern_generator_cw  out  2  00 off, 01 clear LFSR, 10 LFSR, 11 per-lane
o_pi_step  out  PI_STEP_W  current PI step
o_step_pass_map  out  2**PI_STEP_W  bit k = step k passed
o_eye_width  out  PI_STEP_W+1  longest contiguous pass run
o_eye_center  out  PI_STEP_W  centre of that run
o_test_finish_ack  out  1  sweep complete, held until i_en=0
o_timeout_err  out  1  sticky error, cleared on the next start

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Message codes: START_REQ 0001/RESP 0010, CLR_REQ 0011/RESP 0100, RESULT_REQ 0101/RESP 0110, END_REQ 0111/RESP 1000, idle 0000.
- A response counts only when i_rx_valid=1 and the code matches; any other code is ignored.
- States: IDLE, START_REQ, CLR_REQ, SEND_PATTERN, RESULT_REQ, END_REQ, NEXT_STEP, DONE, ERROR.
- IDLE:
  - On i_en rising, latch the configuration and clear the map, eye registers and o_timeout_err.
  - Set o_pi_step = i_step_min, then go to START_REQ.
  - If i_step_min > i_step_max, go straight to DONE with width 0 and centre 0.
- Request issue, on entering any *_REQ state:
  - Drive the code and set o_valid=1 on the next edge.
  - o_valid clears on the cycle after i_busy_negedge_detected && !i_rx_valid; the code is held.
- START_REQ fields:
  - o_sb_comparison_mode=0.
  - o_sb_data_pattern = o_sb_burst_count = i_mainband_or_valtrain_test.
- START_REQ -> CLR_REQ on START_RESP; cw=01 for the whole CLR_REQ state.
- CLR_REQ -> SEND_PATTERN on CLR_RESP; set cw/val_en from {valtrain, perlane}:
  - 00 -> cw=10
  - 01 -> cw=11
  - 1x -> val_en=1, cw=00
- SEND_PATTERN -> RESULT_REQ on i_pattern_finished; generators off the same edge. No timeout in this state.
- RESULT_REQ -> END_REQ on RESULT_RESP.
  - Step pass = &(i_data_bits[NUM_LANES-1:0] | ~i_lane_mask).
  - Write the pass bit to o_step_pass_map[o_pi_step].
- END_REQ -> NEXT_STEP on END_RESP.
- NEXT_STEP (1 cycle), run tracking:
  - On pass, run_len++ and record run_start on the first pass of a run.
  - On fail, run_len=0.
  - If run_len > eye_width (strictly greater, so the earliest window wins a tie), eye_width=run_len and eye_center = run_start + (run_len-1)/2 (floor).
  - If o_pi_step == step_max, go to DONE; else o_pi_step++ and go to START_REQ.
  - No wrap: step_max = 2**PI_STEP_W-1 terminates correctly.
- DONE: o_test_finish_ack=1, o_valid=0, code 0000; go to IDLE when i_en=0.
- Timeout:
  - A per-wait counter resets on every state entry.
  - Reaching TIMEOUT_CYCLES in any *_REQ state -> ERROR: o_timeout_err=1, o_test_finish_ack=1, generators off, o_valid=0.
  - ERROR -> IDLE when i_en=0.
- i_en=0 in any non-IDLE state: next edge -> IDLE; all outputs except map, eye and err return to reset values.
- Response arriving on the same cycle as the timeout expiry: the response wins.
- Response arriving while o_valid is still high: accepted; o_valid clears with the state change.

Decomposition:
- Package ucie_sb_test_pkg: message code constants, cw encodings, state enum.
- One sub-module, eye_window_tracker: run_len, run_start, eye_width and eye_center logic, driven by a step_valid/step_pass/step_idx strobe.

Test Plan:
1. min=4, max=7, mainband LFSR, all responses after 3 cycles, results 0xFFFF -> four handshakes, pi_step 4..7, map=0x00F0, width=4, centre=5, ack=1.
2. min=0, max=9, valtrain; step pass pattern 0,1,1,0,1,1,1,1,0,1 -> width=4, centre=5, val_en=1 only in SEND_PATTERN, cw stays 00.
3. Lane mask 0x00FF, result 0xFF00 at step 2 -> step 2 fails; mask 0xFF00 with the same result -> step 2 passes.
4. Withhold CLR_RESP -> after exactly 8000 cycles in CLR_REQ: o_timeout_err=1, ack=1, cw=00; i_en=0 -> IDLE; restart clears err.
5. min=15, max=15 and min=9, max=3 -> one step then DONE without wrap; empty range gives immediate DONE, width 0.
6. Drop i_en mid SEND_PATTERN with cw=10 -> next cycle IDLE, cw=00, o_valid=0; an asynchronous rst_n pulse mid-RESULT_REQ zeroes all outputs immediately.

Source files
------------

// File: rtl/ucie_sb_test_pkg.sv
// Shared encodings for the TX-initiated sideband sweep test: message codes,
// pattern-generator control words and the controller state set.
package ucie_sb_test_pkg;

   localparam int unsigned MSG_W = 4;
   localparam int unsigned CW_W  = 2;

   localparam logic [MSG_W-1:0] MSG_IDLE        = 4'b0000;
   localparam logic [MSG_W-1:0] MSG_START_REQ   = 4'b0001;
   localparam logic [MSG_W-1:0] MSG_START_RESP  = 4'b0010;
   localparam logic [MSG_W-1:0] MSG_CLR_REQ     = 4'b0011;
   localparam logic [MSG_W-1:0] MSG_CLR_RESP    = 4'b0100;
   localparam logic [MSG_W-1:0] MSG_RESULT_REQ  = 4'b0101;
   localparam logic [MSG_W-1:0] MSG_RESULT_RESP = 4'b0110;
   localparam logic [MSG_W-1:0] MSG_END_REQ     = 4'b0111;
   localparam logic [MSG_W-1:0] MSG_END_RESP    = 4'b1000;

   localparam logic [CW_W-1:0] CW_OFF     = 2'b00;
   localparam logic [CW_W-1:0] CW_CLEAR   = 2'b01;
   localparam logic [CW_W-1:0] CW_LFSR    = 2'b10;
   localparam logic [CW_W-1:0] CW_PERLANE = 2'b11;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START_REQ,
      ST_CLR_REQ,
      ST_SEND_PATTERN,
      ST_RESULT_REQ,
      ST_END_REQ,
      ST_NEXT_STEP,
      ST_DONE,
      ST_ERROR
   } state_e;

   // Response code that completes the wait of a request state.
   function automatic logic [MSG_W-1:0] resp_code(input state_e s);
      case (s)
         ST_START_REQ:  return MSG_START_RESP;
         ST_CLR_REQ:    return MSG_CLR_RESP;
         ST_RESULT_REQ: return MSG_RESULT_RESP;
         ST_END_REQ:    return MSG_END_RESP;
         default:       return MSG_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/eye_window_tracker.sv
// Tracks the longest contiguous run of passing PI steps; the earliest run wins a tie.
module eye_window_tracker #(
   parameter int unsigned PI_STEP_W = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 step_valid,
   input  logic                 step_pass,
   input  logic [PI_STEP_W-1:0] step_idx,
   output logic [PI_STEP_W:0]   eye_width,
   output logic [PI_STEP_W-1:0] eye_center
);

   logic [PI_STEP_W:0]   run_len, run_len_nxt, eye_width_nxt, half;
   logic [PI_STEP_W-1:0] run_start, run_start_nxt, eye_center_nxt;

   always_comb begin
      run_len_nxt    = run_len;
      run_start_nxt  = run_start;
      eye_width_nxt  = eye_width;
      eye_center_nxt = eye_center;
      half           = '0;
      if (clear) begin
         run_len_nxt    = '0;
         run_start_nxt  = '0;
         eye_width_nxt  = '0;
         eye_center_nxt = '0;
      end else if (step_valid) begin
         if (step_pass) begin
            run_len_nxt = run_len + 1'b1;
            if (run_len == '0) run_start_nxt = step_idx;
            if (run_len_nxt > eye_width) begin
               half           = (run_len_nxt - 1'b1) >> 1;
               eye_width_nxt  = run_len_nxt;
               eye_center_nxt = run_start_nxt + half[PI_STEP_W-1:0];
            end
         end else begin
            run_len_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_len    <= '0;
         run_start  <= '0;
         eye_width  <= '0;
         eye_center <= '0;
      end else begin
         run_len    <= run_len_nxt;
         run_start  <= run_start_nxt;
         eye_width  <= eye_width_nxt;
         eye_center <= eye_center_nxt;
      end
   end

endmodule

// File: rtl/tx_initiated_sweep_test_tx.sv
// TX-side PI sweep controller: one sideband point-test handshake per PI step,
// per-step pass map and eye width/centre reporting, with response timeouts.
module tx_initiated_sweep_test_tx
   import ucie_sb_test_pkg::*;
#(
   parameter int unsigned NUM_LANES      = 16,
   parameter int unsigned PI_STEP_W      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 8000,
   parameter int unsigned TO_W           = 13
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_en,
   input  logic                    i_mainband_or_valtrain_test,
   input  logic                    i_lfsr_or_perlane,
   input  logic [PI_STEP_W-1:0]    i_step_min,
   input  logic [PI_STEP_W-1:0]    i_step_max,
   input  logic [NUM_LANES-1:0]    i_lane_mask,
   input  logic                    i_pattern_finished,
   input  logic [3:0]              i_decoded_sideband_message,
   input  logic                    i_rx_valid,
   input  logic [15:0]             i_data_bits,
   input  logic                    i_busy_negedge_detected,
   output logic [3:0]              o_encoded_sideband_message,
   output logic                    o_valid,
   output logic                    o_sb_data_pattern,
   output logic                    o_sb_burst_count,
   output logic                    o_sb_comparison_mode,
   output logic                    o_val_pattern_en,
   output logic [1:0]              o_mainband_pattern_generator_cw,
   output logic [PI_STEP_W-1:0]    o_pi_step,
   output logic [2**PI_STEP_W-1:0] o_step_pass_map,
   output logic [PI_STEP_W:0]      o_eye_width,
   output logic [PI_STEP_W-1:0]    o_eye_center,
   output logic                    o_test_finish_ack,
   output logic                    o_timeout_err
);

   localparam int unsigned MAP_W = 2**PI_STEP_W;

   state_e               state, state_nxt;
   logic                 en_q;
   logic [TO_W-1:0]      to_cnt, to_cnt_nxt;
   logic                 cfg_vt, cfg_vt_nxt, cfg_pl, cfg_pl_nxt;
   logic [PI_STEP_W-1:0] cfg_max, cfg_max_nxt;
   logic [NUM_LANES-1:0] cfg_mask, cfg_mask_nxt;
   logic                 pass_q, pass_nxt;
   logic                 lane_pass, expire, tracker_clear, step_valid;

   logic [3:0]           code_nxt;
   logic                 valid_nxt, pat_nxt, cmp_nxt, val_en_nxt, ack_nxt, err_nxt;
   logic [1:0]           cw_nxt;
   logic [PI_STEP_W-1:0] pi_nxt;
   logic [MAP_W-1:0]     map_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      code_nxt      = o_encoded_sideband_message;
      valid_nxt     = o_valid;
      pat_nxt       = o_sb_data_pattern;
      cmp_nxt       = o_sb_comparison_mode;
      val_en_nxt    = o_val_pattern_en;
      cw_nxt        = o_mainband_pattern_generator_cw;
      pi_nxt        = o_pi_step;
      map_nxt       = o_step_pass_map;
      ack_nxt       = o_test_finish_ack;
      err_nxt       = o_timeout_err;
      cfg_vt_nxt    = cfg_vt;
      cfg_pl_nxt    = cfg_pl;
      cfg_max_nxt   = cfg_max;
      cfg_mask_nxt  = cfg_mask;
      pass_nxt      = pass_q;
      tracker_clear = 1'b0;
      step_valid    = 1'b0;
      expire        = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
      lane_pass     = &(i_data_bits[NUM_LANES-1:0] | ~cfg_mask);

      if (state != ST_IDLE && !i_en) begin
         // Abort: everything but the results and the error flag returns to reset.
         state_nxt  = ST_IDLE;
         code_nxt   = MSG_IDLE;
         valid_nxt  = 1'b0;
         pat_nxt    = 1'b0;
         cmp_nxt    = 1'b0;
         val_en_nxt = 1'b0;
         cw_nxt     = CW_OFF;
         pi_nxt     = '0;
         ack_nxt    = 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_en && !en_q) begin
                  cfg_vt_nxt    = i_mainband_or_valtrain_test;
                  cfg_pl_nxt    = i_lfsr_or_perlane;
                  cfg_max_nxt   = i_step_max;
                  cfg_mask_nxt  = i_lane_mask;
                  map_nxt       = '0;
                  err_nxt       = 1'b0;
                  tracker_clear = 1'b1;
                  pi_nxt        = i_step_min;
                  pat_nxt       = i_mainband_or_valtrain_test;
                  cmp_nxt       = 1'b0;
                  if (i_step_min > i_step_max) begin
                     state_nxt = ST_DONE;
                     ack_nxt   = 1'b1;
                  end else begin
                     state_nxt = ST_START_REQ;
                     code_nxt  = MSG_START_REQ;
                     valid_nxt = 1'b1;
                  end
               end
            end
            ST_START_REQ, ST_CLR_REQ, ST_RESULT_REQ, ST_END_REQ: begin
               if (i_rx_valid && i_decoded_sideband_message == resp_code(state)) begin
                  case (state)
                     ST_START_REQ: begin
                        state_nxt = ST_CLR_REQ;
                        code_nxt  = MSG_CLR_REQ;
                        valid_nxt = 1'b1;
                        cw_nxt    = CW_CLEAR;
                     end
                     ST_CLR_REQ: begin
                        state_nxt  = ST_SEND_PATTERN;
                        valid_nxt  = 1'b0;
                        val_en_nxt = cfg_vt;
                        cw_nxt     = cfg_vt ? CW_OFF : (cfg_pl ? CW_PERLANE : CW_LFSR);
                     end
                     ST_RESULT_REQ: begin
                        state_nxt          = ST_END_REQ;
                        code_nxt           = MSG_END_REQ;
                        valid_nxt          = 1'b1;
                        pass_nxt           = lane_pass;
                        map_nxt[o_pi_step] = lane_pass;
                     end
                     default: begin
                        state_nxt = ST_NEXT_STEP;
                        valid_nxt = 1'b0;
                     end
                  endcase
               end else if (expire) begin
                  state_nxt  = ST_ERROR;
                  err_nxt    = 1'b1;
                  ack_nxt    = 1'b1;
                  cw_nxt     = CW_OFF;
                  val_en_nxt = 1'b0;
                  valid_nxt  = 1'b0;
                  code_nxt   = MSG_IDLE;
               end else if (i_busy_negedge_detected && !i_rx_valid) begin
                  valid_nxt = 1'b0;
               end
            end
            ST_SEND_PATTERN: begin
               if (i_pattern_finished) begin
                  state_nxt  = ST_RESULT_REQ;
                  cw_nxt     = CW_OFF;
                  val_en_nxt = 1'b0;
                  code_nxt   = MSG_RESULT_REQ;
                  valid_nxt  = 1'b1;
               end
            end
            ST_NEXT_STEP: begin
               step_valid = 1'b1;
               if (o_pi_step == cfg_max) begin
                  state_nxt = ST_DONE;
                  ack_nxt   = 1'b1;
                  valid_nxt = 1'b0;
                  code_nxt  = MSG_IDLE;
               end else begin
                  state_nxt = ST_START_REQ;
                  pi_nxt    = o_pi_step + 1'b1;
                  code_nxt  = MSG_START_REQ;
                  valid_nxt = 1'b1;
               end
            end
            default: ;
         endcase
      end

      // Per-wait counter restarts on every state change and saturates at expiry.
      if (state_nxt != state) to_cnt_nxt = '0;
      else if (!expire)       to_cnt_nxt = to_cnt + 1'b1;
      else                    to_cnt_nxt = to_cnt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q                            <= 1'b0;
         to_cnt                          <= '0;
         cfg_vt                          <= 1'b0;
         cfg_pl                          <= 1'b0;
         cfg_max                         <= '0;
         cfg_mask                        <= '0;
         pass_q                          <= 1'b0;
         o_encoded_sideband_message      <= MSG_IDLE;
         o_valid                         <= 1'b0;
         o_sb_data_pattern               <= 1'b0;
         o_sb_burst_count                <= 1'b0;
         o_sb_comparison_mode            <= 1'b0;
         o_val_pattern_en                <= 1'b0;
         o_mainband_pattern_generator_cw <= CW_OFF;
         o_pi_step                       <= '0;
         o_step_pass_map                 <= '0;
         o_test_finish_ack               <= 1'b0;
         o_timeout_err                   <= 1'b0;
      end else begin
         en_q                            <= i_en;
         to_cnt                          <= to_cnt_nxt;
         cfg_vt                          <= cfg_vt_nxt;
         cfg_pl                          <= cfg_pl_nxt;
         cfg_max                         <= cfg_max_nxt;
         cfg_mask                        <= cfg_mask_nxt;
         pass_q                          <= pass_nxt;
         o_encoded_sideband_message      <= code_nxt;
         o_valid                         <= valid_nxt;
         o_sb_data_pattern               <= pat_nxt;
         o_sb_burst_count                <= pat_nxt;
         o_sb_comparison_mode            <= cmp_nxt;
         o_val_pattern_en                <= val_en_nxt;
         o_mainband_pattern_generator_cw <= cw_nxt;
         o_pi_step                       <= pi_nxt;
         o_step_pass_map                 <= map_nxt;
         o_test_finish_ack               <= ack_nxt;
         o_timeout_err                   <= err_nxt;
      end
   end

   eye_window_tracker #(
      .PI_STEP_W (PI_STEP_W)
   ) u_eye (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (tracker_clear),
      .step_valid (step_valid),
      .step_pass  (pass_q),
      .step_idx   (o_pi_step),
      .eye_width  (o_eye_width),
      .eye_center (o_eye_center)
   );

endmodule

// File: tb/tb_tx_initiated_sweep_test_tx.sv
// Bench for the sweep controller: scripted handshakes with random delays and
// sideband noise, a phase-level expectation model and per-cycle output compare.
module tb_tx_initiated_sweep_test_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_en, i_vt, i_pl, i_pattern_finished, i_rx_valid, i_busy;
   logic [3:0]  i_step_min, i_step_max, i_msg;
   logic [15:0] i_lane_mask, i_data_bits;
   logic [3:0]  o_code;
   logic        o_valid, o_pat, o_burst, o_cmp, o_val_en, o_ack, o_err;
   logic [1:0]  o_cw;
   logic [3:0]  o_pi, o_center;
   logic [15:0] o_map;
   logic [4:0]  o_width;

   tx_initiated_sweep_test_tx dut (
      .clk                             (clk),
      .rst_n                           (rst_n),
      .i_en                            (i_en),
      .i_mainband_or_valtrain_test     (i_vt),
      .i_lfsr_or_perlane               (i_pl),
      .i_step_min                      (i_step_min),
      .i_step_max                      (i_step_max),
      .i_lane_mask                     (i_lane_mask),
      .i_pattern_finished              (i_pattern_finished),
      .i_decoded_sideband_message      (i_msg),
      .i_rx_valid                      (i_rx_valid),
      .i_data_bits                     (i_data_bits),
      .i_busy_negedge_detected         (i_busy),
      .o_encoded_sideband_message      (o_code),
      .o_valid                         (o_valid),
      .o_sb_data_pattern               (o_pat),
      .o_sb_burst_count                (o_burst),
      .o_sb_comparison_mode            (o_cmp),
      .o_val_pattern_en                (o_val_en),
      .o_mainband_pattern_generator_cw (o_cw),
      .o_pi_step                       (o_pi),
      .o_step_pass_map                 (o_map),
      .o_eye_width                     (o_width),
      .o_eye_center                    (o_center),
      .o_test_finish_ack               (o_ack),
      .o_timeout_err                   (o_err)
   );

   always #5 clk = ~clk;

   // Expected outputs, maintained by the phase-level script below.
   logic [3:0]  e_code, e_pi, e_c;
   logic        e_valid, e_pat, e_val, e_ack, e_err;
   logic [1:0]  e_cw;
   logic [15:0] e_map;
   logic [4:0]  e_w;
   logic        cfg_vt, cfg_pl;
   logic [3:0]  cfg_mn, cfg_mx;
   logic [15:0] cfg_mask;
   logic [15:0] res_tab [16];
   int          n_pass = 0, n_chk = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   always @(negedge clk) begin
      check("code",  32'(o_code),   32'(e_code));
      check("valid", 32'(o_valid),  32'(e_valid));
      check("pat",   32'(o_pat),    32'(e_pat));
      check("burst", 32'(o_burst),  32'(e_pat));
      check("cmp",   32'(o_cmp),    32'd0);
      check("val_en",32'(o_val_en), 32'(e_val));
      check("cw",    32'(o_cw),     32'(e_cw));
      check("pi",    32'(o_pi),     32'(e_pi));
      check("map",   32'(o_map),    32'(e_map));
      check("width", 32'(o_width),  32'(e_w));
      check("center",32'(o_center), 32'(e_c));
      check("ack",   32'(o_ack),    32'(e_ack));
      check("err",   32'(o_err),    32'(e_err));
   end

   // Longest all-pass window inside [lo,hi], earliest on a tie.
   function automatic void eye_model(input logic [15:0] map, input int lo, input int hi,
                                     output logic [4:0] w, output logic [3:0] c);
      int best, len;
      best = 0; w = '0; c = '0;
      for (int a = lo; a <= hi; a++) begin
         len = 0;
         while (a + len <= hi && map[a + len]) len++;
         if (len > best) begin
            best = len;
            w    = 5'(len);
            c    = 4'(a + (len - 1) / 2);
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_rx_valid = 1'b0; i_msg = 4'h0; i_busy = 1'b0; i_pattern_finished = 1'b0;
   endtask

   task automatic zero_expect();
      e_code = 4'h0; e_valid = 1'b0; e_pat = 1'b0; e_val = 1'b0; e_cw = 2'b00;
      e_pi = 4'h0; e_ack = 1'b0;
   endtask

   // Cycles carrying random busy pulses and wrong-code messages, never the awaited one.
   task automatic noise_cycles(input logic [3:0] resp, input int n);
      for (int k = 0; k < n; k++) begin
         logic b, r;
         logic [3:0] c;
         b = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 4) == 0);
         c = 4'($urandom);
         if (c == resp) c = c + 4'h1;
         i_busy = b; i_rx_valid = r; i_msg = r ? c : 4'h0; i_data_bits = 16'($urandom);
         tick();
         if (b && !r) e_valid = 1'b0;
      end
      idle_inputs();
   endtask

   task automatic wait_resp(input logic [3:0] resp, input int dly, input logic [15:0] data);
      noise_cycles(resp, dly);
      i_rx_valid = 1'b1; i_msg = resp; i_data_bits = data;
      tick();
      idle_inputs();
   endtask

   task automatic start_sweep(input logic vt, input logic pl, input logic [3:0] mn,
                              input logic [3:0] mx, input logic [15:0] mask);
      cfg_vt = vt; cfg_pl = pl; cfg_mn = mn; cfg_mx = mx; cfg_mask = mask;
      i_vt = vt; i_pl = pl; i_step_min = mn; i_step_max = mx; i_lane_mask = mask; i_en = 1'b1;
      tick();
      e_map = '0; e_w = '0; e_c = '0; e_err = 1'b0; e_pi = mn; e_pat = vt;
      if (mn > mx) begin e_ack = 1'b1; e_code = 4'h0; e_valid = 1'b0; end
      else         begin e_code = 4'h1; e_valid = 1'b1; end
      // Configuration is latched at start; scramble the pins afterwards.
      i_vt = 1'($urandom); i_pl = 1'($urandom); i_step_min = 4'($urandom);
      i_step_max = 4'($urandom); i_lane_mask = 16'($urandom);
   endtask

   task automatic step_front(input int dstart);
      wait_resp(4'h2, dstart, 16'h0);
      e_code = 4'h3; e_valid = 1'b1; e_cw = 2'b01;
      wait_resp(4'h4, $urandom_range(0, 5), 16'h0);
      e_valid = 1'b0;
      e_cw    = cfg_vt ? 2'b00 : (cfg_pl ? 2'b11 : 2'b10);
      e_val   = cfg_vt;
      repeat ($urandom_range(0, 4)) tick();
      i_pattern_finished = 1'b1;
      tick();
      i_pattern_finished = 1'b0;
      e_cw = 2'b00; e_val = 1'b0; e_code = 4'h5; e_valid = 1'b1;
   endtask

   task automatic step_back(input int s, input int dres);
      wait_resp(4'h6, dres, res_tab[s]);
      e_map[s] = &(res_tab[s] | ~cfg_mask);
      e_code = 4'h7; e_valid = 1'b1;
      wait_resp(4'h8, $urandom_range(0, 5), 16'h0);
      e_valid = 1'b0;
      tick();
      eye_model(e_map, int'(cfg_mn), s, e_w, e_c);
      if (s == int'(cfg_mx)) begin e_ack = 1'b1; e_code = 4'h0; e_valid = 1'b0; end
      else begin e_pi = 4'(s + 1); e_code = 4'h1; e_valid = 1'b1; end
   endtask

   task automatic run_sweep(input logic vt, input logic pl, input logic [3:0] mn,
                            input logic [3:0] mx, input logic [15:0] mask, input int dly);
      start_sweep(vt, pl, mn, mx, mask);
      if (mn <= mx)
         for (int s = int'(mn); s <= int'(mx); s++) begin
            step_front(dly < 0 ? $urandom_range(0, 6) : dly);
            step_back(s, dly < 0 ? $urandom_range(0, 6) : dly);
         end
      repeat (2) tick();
   endtask

   task automatic end_sweep();
      i_en = 1'b0;
      tick();
      zero_expect();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; i_en = 1'b0; i_vt = 1'b0; i_pl = 1'b0; i_step_min = '0; i_step_max = '0;
      i_lane_mask = '0; i_data_bits = '0;
      idle_inputs();
      zero_expect();
      e_map = '0; e_w = '0; e_c = '0; e_err = 1'b0;
      cfg_vt = 1'b0; cfg_pl = 1'b0; cfg_mn = '0; cfg_mx = '0; cfg_mask = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Mainband LFSR sweep 4..7, all lanes pass, fixed response delay.
      for (int k = 0; k < 16; k++) res_tab[k] = 16'hFFFF;
      run_sweep(1'b0, 1'b0, 4'd4, 4'd7, 16'hFFFF, 3);
      check("t1_map", 32'(o_map), 32'h00F0);
      check("t1_width", 32'(o_width), 32'd4);
      check("t1_center", 32'(o_center), 32'd5);
      check("t1_ack", 32'(o_ack), 32'd1);
      check("t1_pi", 32'(o_pi), 32'd7);
      end_sweep();
      repeat (2) tick();

      // Valtrain sweep 0..9 with pass pattern 0,1,1,0,1,1,1,1,0,1.
      begin
         logic [9:0] pat;
         pat = 10'b10_1111_0110;
         for (int k = 0; k < 16; k++) res_tab[k] = (k < 10 && pat[k]) ? 16'hFFFF : 16'h0000;
      end
      run_sweep(1'b1, 1'b0, 4'd0, 4'd9, 16'hFFFF, -1);
      check("t2_width", 32'(o_width), 32'd4);
      check("t2_center", 32'(o_center), 32'd5);
      check("t2_map", 32'(o_map), 32'h02F6);
      end_sweep();

      // Lane mask: failing lanes outside the mask are ignored.
      res_tab[2] = 16'hFF00;
      run_sweep(1'b0, 1'b1, 4'd2, 4'd2, 16'h00FF, -1);
      check("t3_fail_map", 32'(o_map), 32'h0000);
      check("t3_fail_width", 32'(o_width), 32'd0);
      end_sweep();
      run_sweep(1'b0, 1'b1, 4'd2, 4'd2, 16'hFF00, -1);
      check("t3_pass_map", 32'(o_map), 32'h0004);
      check("t3_pass_center", 32'(o_center), 32'd2);
      end_sweep();

      // CLR_RESP withheld: error after exactly TIMEOUT_CYCLES in CLR_REQ.
      start_sweep(1'b0, 1'b0, 4'd1, 4'd3, 16'hFFFF);
      wait_resp(4'h2, 2, 16'h0);
      e_code = 4'h3; e_valid = 1'b1; e_cw = 2'b01;
      noise_cycles(4'h4, 7999);
      check("t4_err_before", 32'(o_err), 32'd0);
      noise_cycles(4'h4, 1);
      e_err = 1'b1; e_ack = 1'b1; e_cw = 2'b00; e_val = 1'b0; e_valid = 1'b0; e_code = 4'h0;
      check("t4_err", 32'(o_err), 32'd1);
      check("t4_ack", 32'(o_ack), 32'd1);
      check("t4_cw", 32'(o_cw), 32'd0);
      repeat (3) tick();
      end_sweep();
      check("t4_err_sticky", 32'(o_err), 32'd1);
      for (int k = 0; k < 16; k++) res_tab[k] = 16'hFFFF;
      start_sweep(1'b0, 1'b0, 4'd0, 4'd0, 16'hFFFF);
      check("t4_err_cleared", 32'(o_err), 32'd0);
      // Response on the last allowed cycle still wins over the timeout.
      step_front(7999);
      step_back(0, 1);
      check("t4_edge_ack", 32'(o_ack), 32'd1);
      check("t4_edge_err", 32'(o_err), 32'd0);
      repeat (2) tick();
      end_sweep();

      // Top step without wrap, then an empty range.
      run_sweep(1'b0, 1'b0, 4'd15, 4'd15, 16'hFFFF, -1);
      check("t5_pi", 32'(o_pi), 32'd15);
      check("t5_map", 32'(o_map), 32'h8000);
      check("t5_width", 32'(o_width), 32'd1);
      end_sweep();
      run_sweep(1'b0, 1'b0, 4'd9, 4'd3, 16'hFFFF, -1);
      check("t5_empty_ack", 32'(o_ack), 32'd1);
      check("t5_empty_width", 32'(o_width), 32'd0);
      end_sweep();

      // Abort mid-pattern.
      start_sweep(1'b0, 1'b0, 4'd0, 4'd5, 16'hFFFF);
      wait_resp(4'h2, 1, 16'h0);
      e_code = 4'h3; e_valid = 1'b1; e_cw = 2'b01;
      wait_resp(4'h4, 1, 16'h0);
      e_valid = 1'b0; e_cw = 2'b10;
      repeat (2) tick();
      end_sweep();
      check("t6_abort_cw", 32'(o_cw), 32'd0);
      check("t6_abort_valid", 32'(o_valid), 32'd0);
      tick();

      // Asynchronous reset in the middle of RESULT_REQ.
      start_sweep(1'b1, 1'b0, 4'd3, 4'd6, 16'hFFFF);
      step_front(2);
      step_back(3, 2);
      step_front(1);
      noise_cycles(4'h6, 2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(o_valid), 32'd0);
      check("t6_rst_code", 32'(o_code), 32'd0);
      check("t6_rst_map", 32'(o_map), 32'd0);
      check("t6_rst_pi", 32'(o_pi), 32'd0);
      check("t6_rst_width", 32'(o_width), 32'd0);
      zero_expect();
      e_map = '0; e_w = '0; e_c = '0; e_err = 1'b0;
      i_en = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Random sweeps with random configuration and lane results.
      for (int t = 0; t < 5; t++) begin
         logic [3:0]  a, b, tmp;
         logic [15:0] m;
         a = 4'($urandom); b = 4'($urandom);
         if (a > b) begin tmp = a; a = b; b = tmp; end
         m = 16'($urandom);
         for (int k = 0; k < 16; k++)
            res_tab[k] = ($urandom_range(0, 2) != 0) ? (16'($urandom) | m) : 16'($urandom);
         run_sweep(1'($urandom), 1'($urandom), a, b, m, -1);
         end_sweep();
      end

      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
